// File: rtl/sprite_row_drawer_p.sv
// Sprite row renderer: fetches one sprite row from ROM, mirrors/clips it and writes opaque pixels to the line buffer.
// Optional 2x horizontal scaling is compiled in when SPRITE_DRAWER_SCALE2X_EN is defined.
module sprite_row_drawer_p #(
  parameter int SPRITE_W   = 16,
  parameter int SPRITE_H   = 16,
  parameter int FRAME_BITS = 8,
  parameter int PIX_W      = 16,
  parameter int ROM_LAT    = 1,
  parameter int LINE_W     = 640,
  parameter int COL_W      = 11,
  localparam int IDX_W     = $clog2(SPRITE_W),
  localparam int ROW_W     = $clog2(SPRITE_H),
  localparam int ADDR_W    = FRAME_BITS + ROW_W + IDX_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [COL_W-1:0]      col_base,
  input  logic                  flip,
  input  logic [FRAME_BITS-1:0] frame_id,
  input  logic [ROW_W-1:0]      row_off,
  input  logic                  abort,
`ifdef SPRITE_DRAWER_SCALE2X_EN
  input  logic                  scale2x,
`endif
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [PIX_W-1:0]      rom_q,
  output logic [9:0]            pixel_col,
  output logic [PIX_W-1:0]      pixel_data,
  output logic                  wren,
  output logic                  busy,
  output logic                  done
);

  localparam int OFF_W = IDX_W + 1;
  localparam int CW    = COL_W + 1;
  localparam logic [OFF_W-1:0]     LAST_1X    = OFF_W'(SPRITE_W - 1);
  localparam logic [OFF_W-1:0]     LAST_2X    = OFF_W'(2 * SPRITE_W - 1);
  localparam logic [1:0]           DRAIN_LAST = 2'(ROM_LAT - 1);
  localparam logic signed [CW-1:0] LINE_LIM   = CW'(LINE_W);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t                r_state, w_state_nxt;
  logic [COL_W-1:0]      r_col_base;
  logic                  r_flip;
  logic [FRAME_BITS-1:0] r_frame;
  logic [ROW_W-1:0]      r_row;
  logic [OFF_W-1:0]      r_step;
  logic [1:0]            r_drain;
  logic                  r_done;
  logic [ROM_LAT-1:0]    r_vld;
  logic [OFF_W-1:0]      r_pstep [ROM_LAT];

  logic                  w_scale;
  logic [OFF_W-1:0]      w_span_last;
  logic                  w_fetch_end, w_drain_end, w_accept, w_kill;
  logic                  w_out_vld;
  logic [OFF_W-1:0]      w_out_step, w_off;
  logic signed [CW-1:0]  w_col;
  logic                  w_onscreen;
  logic [IDX_W-1:0]      w_rom_idx;

`ifdef SPRITE_DRAWER_SCALE2X_EN
  logic r_scale;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_scale <= 1'b0;
    else if (w_accept) r_scale <= scale2x;
  end
  assign w_scale = r_scale;
`else
  assign w_scale = 1'b0;
`endif

  // Each pixel step is one output column; in 2x mode two steps share one ROM index.
  assign w_span_last = w_scale ? LAST_2X : LAST_1X;
  assign w_fetch_end = (r_state == S_FETCH) && (r_step == w_span_last);
  assign w_drain_end = (r_state == S_DRAIN) && (r_drain == DRAIN_LAST);
  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_kill      = (r_state != S_IDLE) && abort;

  always_comb begin
    // NOTE: default assigned first so every path drives the signal and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (abort)            w_state_nxt = S_IDLE;
        else if (w_fetch_end) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (abort || w_drain_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col_base <= '0;
      r_flip     <= 1'b0;
      r_frame    <= '0;
      r_row      <= '0;
      r_step     <= '0;
      r_drain    <= '0;
      r_done     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_col_base <= col_base;
        r_flip     <= flip;
        r_frame    <= frame_id;
        r_row      <= row_off;
        r_step     <= '0;
      end else if (r_state == S_FETCH) begin
        r_step <= r_step + OFF_W'(1);
      end
      r_drain <= (r_state == S_DRAIN) ? r_drain + 2'd1 : 2'd0;
      r_done  <= w_kill || w_drain_end;
    end
  end

  // Valid/step pipe aligned with rom_q; abort empties it so nothing is written after the abort edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the step payload is reset with the valids so the pipe never holds X after reset.
      for (int k = 0; k < ROM_LAT; k++) begin
        r_vld[k]   <= 1'b0;
        r_pstep[k] <= '0;
      end
    end else begin
      for (int k = ROM_LAT - 1; k > 0; k--) begin
        r_vld[k]   <= r_vld[k-1] && !w_kill;
        r_pstep[k] <= r_pstep[k-1];
      end
      r_vld[0]   <= (r_state == S_FETCH) && !w_kill;
      r_pstep[0] <= r_step;
    end
  end

  assign w_out_vld  = r_vld[ROM_LAT-1];
  assign w_out_step = r_pstep[ROM_LAT-1];
  assign w_off      = r_flip ? (w_span_last - w_out_step) : w_out_step;
  assign w_col      = {r_col_base[COL_W-1], r_col_base} + {{(CW - OFF_W){1'b0}}, w_off};
  assign w_onscreen = !w_col[CW-1] && (w_col < LINE_LIM);

  assign wren       = w_out_vld && !rom_q[PIX_W-1] && w_onscreen;
  assign pixel_col  = w_out_vld ? w_col[9:0] : 10'd0;
  assign pixel_data = rom_q;

  assign w_rom_idx  = w_scale ? r_step[OFF_W-1:1] : r_step[IDX_W-1:0];
  assign rom_addr   = {r_frame, r_row, w_rom_idx};
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;

endmodule

// File: tb/tb_sprite_row_drawer_p.sv
// Bench for sprite_row_drawer_p: two instances (ROM_LAT 1 and 3) share stimulus; a per-cycle
// expectation model built from the row rules checks every output, plus table and hand-written runs.
module tb_sprite_row_drawer_p;

  localparam int W  = 16;
  localparam int NC = 8192;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, flip, abort, scale2x;
  logic [10:0] col_base;
  logic [7:0]  frame_id;
  logic [3:0]  row_off;

  logic [15:0] addr [2];
  logic [15:0] rq   [2];
  logic [9:0]  pcol [2];
  logic [15:0] pdat [2];
  logic        wr [2], bz [2], dn [2];

  logic [15:0] mem [65536];
  logic [15:0] ap0;
  logic [15:0] ap1 [3];

  int lat_of [2] = '{1, 3};
  int cyc = 0;
  int n_vec = 0, n_err = 0;
  bit mon_en = 1'b0;

  bit          e_busy [2][NC];
  bit          e_done [2][NC];
  bit          e_wren [2][NC];
  bit          e_av   [2][NC];
  int          e_col  [2][NC];
  logic [15:0] e_dat  [2][NC];
  logic [15:0] e_addr [2][NC];

  int r_cnt [2], r_first [2], r_last [2], r_done_off [2];

  sprite_row_drawer_p #(.ROM_LAT(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .col_base(col_base), .flip(flip),
    .frame_id(frame_id), .row_off(row_off), .abort(abort),
`ifdef SPRITE_DRAWER_SCALE2X_EN
    .scale2x(scale2x),
`endif
    .rom_addr(addr[0]), .rom_q(rq[0]), .pixel_col(pcol[0]), .pixel_data(pdat[0]),
    .wren(wr[0]), .busy(bz[0]), .done(dn[0]));

  sprite_row_drawer_p #(.ROM_LAT(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .col_base(col_base), .flip(flip),
    .frame_id(frame_id), .row_off(row_off), .abort(abort),
`ifdef SPRITE_DRAWER_SCALE2X_EN
    .scale2x(scale2x),
`endif
    .rom_addr(addr[1]), .rom_q(rq[1]), .pixel_col(pcol[1]), .pixel_data(pdat[1]),
    .wren(wr[1]), .busy(bz[1]), .done(dn[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM models with 1 and 3 cycles of read latency.
  always @(posedge clk) begin
    ap0    <= addr[0];
    ap1[0] <= addr[1];
    ap1[1] <= ap1[0];
    ap1[2] <= ap1[1];
  end
  assign rq[0] = mem[ap0];
  assign rq[1] = mem[ap1[2]];

  task automatic check(string name, int k, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d cyc=%0d got=%0h exp=%0h", name, k, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && cyc < NC - 64) begin
      for (int k = 0; k < 2; k++) begin
        check("busy", k, 64'(bz[k]), 64'(e_busy[k][cyc]));
        check("done", k, 64'(dn[k]), 64'(e_done[k][cyc]));
        check("wren", k, 64'(wr[k]), 64'(e_wren[k][cyc]));
        if (e_wren[k][cyc]) begin
          check("pixel_col", k, 64'(pcol[k]), 64'(e_col[k][cyc]));
          check("pixel_data", k, 64'(pdat[k]), 64'(e_dat[k][cyc]));
        end
        if (e_av[k][cyc]) check("rom_addr", k, 64'(addr[k]), 64'(e_addr[k][cyc]));
      end
    end
  end

  // Expected outputs of a row accepted in cycle t, derived directly from the row rules.
  task automatic plan(int k, int t, int base, bit fl, int frm, int row, bit sc);
    int span, l, col, idx, c;
    logic [15:0] a;
    span = sc ? 2 * W : W;
    l    = lat_of[k];
    for (int cc = t + 1; cc <= t + span + l; cc++) e_busy[k][cc] = 1'b1;
    e_done[k][t + span + l + 1] = 1'b1;
    for (int s = 0; s < span; s++) begin
      col = base + (fl ? span - 1 - s : s);
      idx = sc ? s / 2 : s;
      a   = 16'(frm * 256 + row * 16 + idx);
      e_av[k][t + 1 + s]   = 1'b1;
      e_addr[k][t + 1 + s] = a;
      c = t + 1 + s + l;
      e_wren[k][c] = !mem[a][15] && col >= 0 && col < 640;
      e_col[k][c]  = col;
      e_dat[k][c]  = mem[a];
    end
  endtask

  task automatic clear_from(int k, int c0);
    for (int c = c0; c < c0 + 40; c++) begin
      e_busy[k][c] = 1'b0;
      e_done[k][c] = 1'b0;
      e_wren[k][c] = 1'b0;
      e_av[k][c]   = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(int base, bit fl, int frm, int row, bit sc);
    start    = 1'b1;
    col_base = 11'(base);
    flip     = fl;
    frame_id = 8'(frm);
    row_off  = 4'(row);
    scale2x  = sc;
    for (int k = 0; k < 2; k++)
      if (!e_busy[k][cyc]) plan(k, cyc, base, fl, frm, row, sc);
    tick();
    start    = 1'b0;
    col_base = 11'($urandom);
    flip     = 1'($urandom);
    frame_id = 8'($urandom);
    row_off  = 4'($urandom);
    scale2x  = 1'($urandom);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    for (int k = 0; k < 2; k++)
      if (e_busy[k][cyc]) begin
        clear_from(k, cyc + 1);
        e_done[k][cyc + 1] = 1'b1;
      end
    tick();
    abort = 1'b0;
  endtask

  task automatic run_collect(int base, bit fl, int frm, int row, bit sc);
    int t;
    t = cyc;
    for (int k = 0; k < 2; k++) begin
      r_cnt[k] = 0; r_first[k] = -1; r_last[k] = -1; r_done_off[k] = -1;
    end
    do_start(base, fl, frm, row, sc);
    repeat (45) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (wr[k]) begin
          if (r_cnt[k] == 0) r_first[k] = int'(pcol[k]);
          r_last[k] = int'(pcol[k]);
          r_cnt[k]++;
        end
        if (dn[k] && r_done_off[k] < 0) r_done_off[k] = cyc - t;
      end
    end
    tick();
  endtask

  typedef struct {
    int base;
    bit fl;
    int cnt;
    int first;
    int last;
  } vec_t;
  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int t, n, ab, base;
    bit sc;

    tbl[0] = '{base: 100, fl: 1'b0, cnt: 16, first: 100, last: 115};
    tbl[1] = '{base: 100, fl: 1'b1, cnt: 16, first: 115, last: 100};
    tbl[2] = '{base: -4,  fl: 1'b0, cnt: 12, first: 0,   last: 11};
    tbl[3] = '{base: 630, fl: 1'b0, cnt: 10, first: 630, last: 639};
    tbl[4] = '{base: -16, fl: 1'b0, cnt: 0,  first: -1,  last: -1};
    tbl[5] = '{base: 640, fl: 1'b1, cnt: 0,  first: -1,  last: -1};
    tbl[6] = '{base: -15, fl: 1'b1, cnt: 1,  first: 0,   last: 0};

    for (int a = 0; a < 65536; a++) begin
      mem[a] = 16'($urandom);
      mem[a][15] = ($urandom_range(0, 3) == 0);
    end
    for (int a = 16'h0300; a < 16'h0400; a++) mem[a][15] = 1'b0;
    for (int i = 0; i < 16; i++) mem[16'h0450 + i][15] = (i == 2 || i == 7);

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; flip = 1'b0; scale2x = 1'b0;
    col_base = '0; frame_id = '0; row_off = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_rom_addr", k, 64'(addr[k]), 64'd0);
      check("rst_pixel_col", k, 64'(pcol[k]), 64'd0);
      check("rst_wren", k, 64'(wr[k]), 64'd0);
      check("rst_busy", k, 64'(bz[k]), 64'd0);
      check("rst_done", k, 64'(dn[k]), 64'd0);
    end
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (2) tick();

    // Address sequence for frame 3 row 5.
    do_start(100, 1'b0, 3, 5, 1'b0);
    check("addr_idx0", 0, 64'(addr[0]), 64'h0350);
    repeat (15) tick();
    check("addr_idx15", 0, 64'(addr[0]), 64'h035F);
    repeat (25) tick();

    // Placement/clipping table; done latency per instance.
    for (int i = 0; i < 7; i++) begin
      run_collect(tbl[i].base, tbl[i].fl, 3, 5, 1'b0);
      for (int k = 0; k < 2; k++) begin
        check("tbl_count", k, 64'(r_cnt[k]), 64'(tbl[i].cnt));
        check("tbl_first_col", k, 64'(r_first[k]), 64'(tbl[i].first));
        check("tbl_last_col", k, 64'(r_last[k]), 64'(tbl[i].last));
        check("tbl_done_lat", k, 64'(r_done_off[k]), 64'(W + lat_of[k] + 1));
      end
    end

    // Transparent pixels at idx 2 and 7.
    run_collect(200, 1'b0, 4, 5, 1'b0);
    for (int k = 0; k < 2; k++) check("transp_count", k, 64'(r_cnt[k]), 64'd14);

    // Start while busy ignored, abort (with simultaneous start) at T+6, restart in done cycle.
    t = cyc;
    do_start(100, 1'b0, 3, 5, 1'b0);
    tick(); tick();
    do_start(300, 1'b1, 9, 2, 1'b0);
    tick(); tick();
    start = 1'b1; col_base = 11'd20;
    pulse_abort();
    start = 1'b0;
    check("abort_done_at_T7", 0, 64'(cyc - t), 64'd7);
    for (int k = 0; k < 2; k++) begin
      check("abort_done", k, 64'(dn[k]), 64'd1);
      check("abort_busy", k, 64'(bz[k]), 64'd0);
    end
    do_start(50, 1'b0, 3, 1, 1'b0);
    for (int k = 0; k < 2; k++) check("restart_busy", k, 64'(bz[k]), 64'd1);
    repeat (25) tick();

    // Reset mid-row: outputs clear immediately, no done afterwards.
    do_start(100, 1'b0, 3, 5, 1'b0);
    repeat (4) tick();
    for (int k = 0; k < 2; k++) clear_from(k, cyc);
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("midrst_rom_addr", k, 64'(addr[k]), 64'd0);
      check("midrst_pixel_col", k, 64'(pcol[k]), 64'd0);
      check("midrst_wren", k, 64'(wr[k]), 64'd0);
      check("midrst_busy", k, 64'(bz[k]), 64'd0);
    end
    tick(); tick();
    reset_n = 1'b1;
    repeat (25) tick();

`ifdef SPRITE_DRAWER_SCALE2X_EN
    run_collect(100, 1'b0, 3, 5, 1'b1);
    check("scale_count", 0, 64'(r_cnt[0]), 64'd32);
    check("scale_last_col", 0, 64'(r_last[0]), 64'd131);
    check("scale_done_lat", 0, 64'(r_done_off[0]), 64'd34);
    run_collect(100, 1'b1, 3, 5, 1'b1);
    check("scale_flip_first", 0, 64'(r_first[0]), 64'd131);
`endif

    // Randomized rows with overlapping starts and occasional aborts.
    for (int r = 0; r < 60; r++) begin
      base = int'($urandom_range(0, 760)) - 60;
`ifdef SPRITE_DRAWER_SCALE2X_EN
      sc = 1'($urandom);
`else
      sc = 1'b0;
`endif
      do_start(base, 1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), sc);
      n  = int'($urandom_range(0, 24));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : -1;
      for (int i = 0; i < n; i++) begin
        if (i == ab) pulse_abort();
        else         tick();
      end
    end
    repeat (45) tick();

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
